// File: rtl/seg_scan_ctrl.sv
// N-digit multiplexed 7-segment scan controller with write port and leading-zero suppression.
// Optional blinking via SEG_SCAN_CTRL_BLINK_EN (adds blink_mask port and BLINK_TICKS parameter).
module seg_scan_ctrl #(
    parameter int unsigned DIGITS      = 8,
`ifdef SEG_SCAN_CTRL_BLINK_EN
    parameter int unsigned BLINK_TICKS = 200,
`endif
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned SCAN_HZ     = 800
) (
    input  logic                      clk_50mhz,
    input  logic                      rst,
    input  logic                      n_en,
    input  logic                      wr_en,
    input  logic [$clog2(DIGITS)-1:0] wr_addr,
    input  logic [3:0]                wr_data,
    input  logic                      lz_en,
`ifdef SEG_SCAN_CTRL_BLINK_EN
    input  logic [DIGITS-1:0]         blink_mask,
`endif
    output logic [DIGITS-1:0]         ds,
    output logic [6:0]                led
);

    localparam int unsigned AW  = $clog2(DIGITS);
    localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned CW  = $clog2(DIV);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [3:0]        digit_q [DIGITS];
    logic [DIGITS-1:0] ds_q, ds_d;
    logic [6:0]        led_q, led_d;
    logic              tick;
    logic              upper_nz;
    logic              blank;
    logic              blink_off;

    function automatic logic [6:0] seg(input logic [3:0] v);
        unique case (v)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
    endfunction

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == AW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // A digit is a leading zero when it and every digit to its left hold 0.
    always_comb begin
        upper_nz = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (j >= int'(idx_q) && digit_q[j] != 4'h0) begin
                upper_nz = 1'b1;
            end
        end
        blank = lz_en && (idx_q != '0) && !upper_nz;
    end

`ifdef SEG_SCAN_CTRL_BLINK_EN
    localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (tick) begin
            if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_off = phase_q && blink_mask[idx_q];
`else
    assign blink_off = 1'b0;
`endif

    always_comb begin
        ds_d  = '0;
        led_d = '0;
        if (!n_en) begin
            ds_d[idx_q] = 1'b1;
            if (!blank && !blink_off) begin
                led_d = seg(digit_q[idx_q]);
            end
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            ds_q  <= '0;
            led_q <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                digit_q[i] <= 4'h0;
            end
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            ds_q  <= ds_d;
            led_q <= led_d;
            // Out-of-range addresses are dropped.
            if (wr_en && (32'(wr_addr) < DIGITS)) begin
                digit_q[wr_addr] <= wr_data;
            end
        end
    end

    assign ds  = ds_q;
    assign led = led_q;

endmodule
